llc_req_queue: RTL and testbench
================================

# llc_req_queue

Request queue and issue stage that sits directly upstream of the LLC model. It accepts (operation, address) trace commands from the trace reader, buffers them in a FIFO, and presents one command per cycle on the LLC `op`/`addr` inputs. It honours the LLC `hold` back-pressure by keeping the presented command stable while `hold` is high. When it has nothing to issue, it drives the idle code.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `ADDR_WIDTH`, 32: address width.
- `IDLE_OP`, 4'd8: op code driven when no command is presented.
- `clk` input 1: single clock; all state changes on posedge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: trace command present.
- `in_ready` output 1: queue can accept; equals `count < DEPTH`.
- `in_op` input 4: op code 0–9 (0/1/2 L1 read/write/ifetch, 3–6 snoops, 8 clear, 9 print).
- `in_addr` input ADDR_WIDTH: command address.
- `hold` input 1: from LLC; the presented command must stay one more cycle.
- `op` output 4: op to LLC.
- `addr` output ADDR_WIDTH: address to LLC.
- `count` output $clog2(DEPTH)+1: FIFO occupancy; excludes the presented command.
- `issued` output 32: number of commands presented to the LLC, excluding idle.
- `dropped` output 16: number of rejected invalid ops (see Configuration).

## Operation
- FIFO: circular buffer with read/write pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
- Push: `in_valid && in_ready` at a posedge writes `{in_op,in_addr}` and increments `count`.
- Issue register `{op,addr}`: at a posedge with `hold==0`:
  - if `count>0`, load the FIFO head, pop it, and increment `issued`;
  - else load `{IDLE_OP, addr unchanged}`.
- At a posedge with `hold==1`: `op`, `addr` and the FIFO head are unchanged; pushes still proceed.
- Push and pop in the same cycle leave `count` unchanged. A push is never bypassed into the issue register; it must pass through the FIFO.
- Full: `in_ready=0`. A simultaneous pop does not raise `in_ready` in that cycle.
- `hold` while `op==IDLE_OP` still stalls, and has no other effect.
- `issued` saturates at 2^32−1. `dropped` saturates at 2^16−1.
- Reset values: `op=IDLE_OP`, `addr=0`, `count=0`, `in_ready=1`, `issued=0`, `dropped=0`, pointers 0.
- Reset asserted mid-operation: queued and presented commands are discarded. The cycle after reset deasserts behaves as from empty.

## Timing
- Latency: a push at edge N into an empty queue with `hold` low appears on `op`/`addr` after edge N+1.
- Each non-idle command is presented for 1 + (number of consecutive cycles `hold` is sampled high while it is presented) cycles.
- Throughput: 1 command/cycle when `hold` stays low and `in_valid` is continuous.
- `in_ready` and `count` are registered-state derived. No combinational path from `hold` to `in_ready`.

## Configuration
- `LLC_REQ_FILTER_EN` defined:
  - pushes with `in_op` of 7 or 10–15 are accepted (they consume the handshake) but not written;
  - `count` is unchanged and `dropped` increments.
- `LLC_REQ_FILTER_EN` undefined:
  - all op codes are enqueued and issued unchanged;
  - `dropped` is tied to 0.

## Test plan
- Reset, then idle 5 cycles → `op=8`, `addr=0`, `count=0`, `in_ready=1`, `issued=0`.
- Push (0,0x1000), (1,0x2000), (9,0x0) back-to-back with `hold=0` → `op` shows 0, 1, 9 on consecutive cycles, first one after the second edge; then `op=8`; `issued=3`.
- Present (0,0x1000) with `hold=1` for 2 cycles → `op/addr` stable 3 cycles; next entry follows on the cycle after `hold` falls; `issued` increments once.
- Hold high, push 8 entries → `count=8`, `in_ready=0`. 9th push not accepted. Release hold → entries issue in order; pointer wrap is verified by pushing 4 more afterwards.
- `LLC_REQ_FILTER_EN` defined, push ops 7, 12, 3 → only op 3 issued, `dropped=2`, `issued=1`. With the macro undefined → all three issued, `dropped=0`.
- Assert `rst` with `count=5` and `hold=1` → next cycle `op=8`, `count=0`, `issued=0`. No stale entry issues afterwards.

Source files
------------

// File: rtl/llc_req_queue.sv
// llc_req_queue: request FIFO and issue register feeding the LLC model.
// Trace commands are buffered in a circular FIFO and presented one per cycle
// on op/addr; the presented command is frozen while the LLC raises hold.
// Optional build macro: LLC_REQ_FILTER_EN -- when defined, pushes carrying
// op 7 or 10..15 are accepted but discarded and counted in `dropped`.
module llc_req_queue #(
  parameter int         DEPTH      = 8,
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] IDLE_OP    = 4'd8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic                    hold,
  output logic [3:0]              op,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             issued,
  output logic [15:0]             dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 + ADDR_WIDTH;

  logic [EW-1:0]         mem_reg [DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic [3:0]            op_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           issued_reg;
  logic                  push_en;
  logic                  write_en;
  logic                  pop_en;

  // in_ready depends only on registered occupancy, so a same-cycle pop
  // never opens a slot and hold has no path to in_ready.
  assign in_ready = (count_reg < CW'(DEPTH));
  assign push_en  = in_valid && in_ready;
  assign pop_en   = !hold && (count_reg != '0);

`ifdef LLC_REQ_FILTER_EN
  logic        drop_en;
  logic [15:0] dropped_reg;

  // Reserved/unsupported op codes consume the handshake but never enter the FIFO.
  assign drop_en  = push_en && ((in_op == 4'd7) || (in_op >= 4'd10));
  assign write_en = push_en && !drop_en;

  // Saturating count of filtered pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_reg <= '0;
    end else if (drop_en && (dropped_reg != 16'hFFFF)) begin
      dropped_reg <= dropped_reg + 16'd1;
    end
  end

  assign dropped = dropped_reg;
`else
  assign write_en = push_en;
  assign dropped  = '0;
`endif

  assign count_next = count_reg + CW'(write_en) - CW'(pop_en);

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_reg[wr_ptr_reg] <= {in_op, in_addr};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (write_en) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Issue register: frozen under hold, else loads the head or goes idle
  // (address is left as-is when idling).
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= IDLE_OP;
      addr_reg <= '0;
    end else if (!hold) begin
      if (count_reg != '0) begin
        {op_reg, addr_reg} <= mem_reg[rd_ptr_reg];
      end else begin
        op_reg <= IDLE_OP;
      end
    end
  end

  // Saturating count of real (non-idle) commands handed to the LLC.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_reg <= '0;
    end else if (pop_en && (issued_reg != 32'hFFFF_FFFF)) begin
      issued_reg <= issued_reg + 32'd1;
    end
  end

  assign op     = op_reg;
  assign addr   = addr_reg;
  assign count  = count_reg;
  assign issued = issued_reg;

endmodule

// File: tb/tb_llc_req_queue.sv
// tb_llc_req_queue: directed stimulus with a scoreboard; a negedge monitor
// pops expected commands whenever a new non-idle command is presented.
module tb_llc_req_queue;

  localparam logic [3:0] IDLE = 4'd8;
`ifdef LLC_REQ_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic        hold;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [3:0]  count;
  logic [31:0] issued;
  logic [15:0] dropped;

  int checks = 0;
  int errors = 0;
  int exp_issued = 0;
  int exp_dropped = 0;
  logic [35:0] sb[$];

  llc_req_queue #(.DEPTH(8), .ADDR_WIDTH(32), .IDLE_OP(4'd8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .hold(hold), .op(op), .addr(addr),
    .count(count), .issued(issued), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit kept(input logic [3:0] o);
    return !(FILTER_EN && ((o == 4'd7) || (o >= 4'd10)));
  endfunction

  // Offer one command for one edge; records the expected outcome first.
  task automatic push(input logic [3:0] o, input logic [31:0] a, input bit exp_ready);
    in_valid = 1'b1;
    in_op    = o;
    in_addr  = a;
    check("in_ready_before_push", in_ready, exp_ready);
    if (exp_ready) begin
      if (kept(o)) begin
        sb.push_back({o, a});
        exp_issued++;
      end else begin
        exp_dropped++;
      end
    end
    $display("push op=%0d addr=%h expect_accept=%0d", o, a, exp_ready);
    tick();
  endtask

  // Monitor: state seen at negedge k+1 reflects the edge that sampled the
  // hold/rst values recorded at negedge k.
  logic        l_rst  = 1'b1;
  logic        l_hold = 1'b0;
  logic [3:0]  l_op   = IDLE;
  logic [31:0] l_addr = '0;

  always @(negedge clk) begin
    logic [35:0] e;
    if (l_rst) begin
      check("reset_op", op, IDLE);
      check("reset_addr", addr, 0);
    end else if (l_hold) begin
      check("hold_op_stable", op, l_op);
      check("hold_addr_stable", addr, l_addr);
    end else if (op != IDLE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got op=%0d addr=%h expected nothing", op, addr);
      end else begin
        e = sb.pop_front();
        check("issue_op", op, e[35:32]);
        check("issue_addr", addr, e[31:0]);
        $display("issue op=%0d addr=%h", op, addr);
      end
    end
    l_rst  = rst;
    l_hold = hold;
    l_op   = op;
    l_addr = addr;
  end

  initial begin
    rst = 1'b1; hold = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_op", op, IDLE);
    check("idle_addr", addr, 0);
    check("idle_count", count, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_issued", issued, 0);
    check("idle_dropped", dropped, 0);

    // Back-to-back pushes: first command appears after the second edge.
    push(4'd0, 32'h1000, 1'b1);
    check("latency_not_bypassed", op, IDLE);
    check("count_after_first", count, 1);
    push(4'd1, 32'h2000, 1'b1);
    check("b2b_op0", op, 4'd0);
    push(4'd9, 32'h0, 1'b1);
    check("b2b_op1", op, 4'd1);
    in_valid = 1'b0;
    tick();
    check("b2b_op9", op, 4'd9);
    tick();
    check("b2b_idle", op, IDLE);
    check("b2b_issued", issued, 3);

    // Hold for two cycles on a presented command.
    push(4'd0, 32'h1000, 1'b1);
    check("hold_pre_op", op, IDLE);
    push(4'd2, 32'h3000, 1'b1);
    in_valid = 1'b0;
    hold = 1'b1;
    check("hold_cycle1_op", op, 4'd0);
    tick();
    check("hold_cycle2_op", op, 4'd0);
    check("hold_count", count, 1);
    tick();
    check("hold_cycle3_addr", addr, 32'h1000);
    check("hold_issued_once", issued, 32'(exp_issued - 1));
    hold = 1'b0;
    tick();
    check("after_hold_op", op, 4'd2);
    check("after_hold_addr", addr, 32'h3000);
    tick();
    check("after_hold_idle", op, IDLE);
    check("after_hold_issued", issued, 32'(exp_issued));

    // Hold while idle: nothing changes.
    hold = 1'b1;
    tick(); tick();
    check("idle_hold_op", op, IDLE);
    check("idle_hold_count", count, 0);

    // Fill to full under hold, reject the 9th, then release.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] o;
      o = (i == 7) ? 4'd9 : 4'(i);
      push(o, 32'h100 * (i + 1), 1'b1);
    end
    check("full_count", count, 8);
    check("full_in_ready", in_ready, 0);
    push(4'd3, 32'hDEAD, 1'b0);
    check("full_count_after_reject", count, 8);
    in_op = 4'd4; in_addr = 32'hBEEF;
    hold = 1'b0;
    check("full_pop_no_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check("after_pop_count", count, 7);
    check("after_pop_in_ready", in_ready, 1);
    check("after_pop_op", op, 4'd0);
    repeat (8) tick();
    check("drain_idle", op, IDLE);
    check("drain_count", count, 0);
    // Pointers have wrapped; four more must still issue in order.
    push(4'd0, 32'hA000, 1'b1);
    push(4'd1, 32'hA001, 1'b1);
    push(4'd2, 32'hA002, 1'b1);
    push(4'd9, 32'hA003, 1'b1);
    in_valid = 1'b0;
    repeat (5) tick();
    check("wrap_idle", op, IDLE);
    check("wrap_issued", issued, 32'(exp_issued));

    // Filter behaviour (build dependent).
    push(4'd7, 32'h7000, 1'b1);
    push(4'd12, 32'hC000, 1'b1);
    push(4'd3, 32'h3300, 1'b1);
    in_valid = 1'b0;
    repeat (4) tick();
    check("filter_dropped", dropped, FILTER_EN ? 16'd2 : 16'd0);
    check("filter_dropped_model", dropped, 16'(exp_dropped));
    check("filter_issued", issued, 32'(exp_issued));

    // Reset mid-operation with 5 queued and hold high.
    hold = 1'b1;
    push(4'd0, 32'h5000, 1'b1);
    push(4'd1, 32'h5001, 1'b1);
    push(4'd2, 32'h5002, 1'b1);
    push(4'd4, 32'h5004, 1'b1);
    push(4'd5, 32'h5005, 1'b1);
    in_valid = 1'b0;
    check("prereset_count", count, 5);
    rst = 1'b1;
    tick();
    sb.delete();
    exp_issued = 0;
    exp_dropped = 0;
    check("rst_op", op, IDLE);
    check("rst_addr", addr, 0);
    check("rst_count", count, 0);
    check("rst_issued", issued, 0);
    check("rst_dropped", dropped, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    hold = 1'b0;
    repeat (3) tick();
    check("post_rst_op", op, IDLE);
    check("post_rst_issued", issued, 0);
    push(4'd1, 32'h4242, 1'b1);
    in_valid = 1'b0;
    tick(); tick();
    check("post_rst_issue_count", issued, 1);
    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
